// File: rtl/atm_session_ctrl.sv
// -----------------------------------------------------------------------------
// atm_session_ctrl
//
// Session sequencer for one ATM transaction. Accepts a card, requests a
// password/balance load from the account storage block, checks the PIN with
// a retry limit, serves balance/withdraw/deposit requests against a working
// balance and finally ejects the card.
//
// Ports
//   clk             in   system clock, all logic on the rising edge
//   rst             in   asynchronous active-high reset
//   card_inserted   in   1-cycle pulse, card presented (IDLE only)
//   card_number     in   card ID, sampled with card_inserted
//   pin             in   entered PIN
//   pin_valid       in   1-cycle pulse, pin is valid (WAIT_PIN only)
//   stored_psw      in   password from storage block
//   stored_balance  in   balance from storage block
//   op_valid        in   1-cycle pulse, operation request (MENU only)
//   op_code         in   00 balance, 01 withdraw, 10 deposit, 11 exit
//   amount          in   operand for withdraw/deposit
//   card_sel        out  latched card ID to storage block
//   card_in         out  load strobe to storage block
//   card_out        out  eject strobe (storage writes back on it)
//   op_done         out  operation-complete strobe (storage writes back on it)
//   updated_balance out  working balance
//   balance_out     out  balance shown to the user
//   wrong_id        out  pulse, invalid card ID
//   wrong_psw       out  pulse, PIN mismatch
//   locked          out  pulse, retry limit reached
//   op_err          out  pulse, withdraw underflow or deposit overflow
//   state           out  IDLE=0, LOAD=1, WAIT_PIN=2, MENU=3, EJECT=4
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module atm_session_ctrl #(
   parameter int card_width     = 6,
   parameter int password_width = 16,
   parameter int balance_width  = 20,
   parameter int users_num      = 10,
   parameter int max_tries      = 3,
   parameter int timeout_cycles = 1000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      card_inserted,
   input  logic [card_width-1:0]     card_number,
   input  logic [password_width-1:0] pin,
   input  logic                      pin_valid,
   input  logic [password_width-1:0] stored_psw,
   input  logic [balance_width-1:0]  stored_balance,
   input  logic                      op_valid,
   input  logic [1:0]                op_code,
   input  logic [balance_width-1:0]  amount,
   output logic [card_width-1:0]     card_sel,
   output logic                      card_in,
   output logic                      card_out,
   output logic                      op_done,
   output logic [balance_width-1:0]  updated_balance,
   output logic [balance_width-1:0]  balance_out,
   output logic                      wrong_id,
   output logic                      wrong_psw,
   output logic                      locked,
   output logic                      op_err,
   output logic [2:0]                state
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD     = 3'd1,
      WAIT_PIN = 3'd2,
      MENU     = 3'd3,
      EJECT    = 3'd4
   } state_t;

   localparam int tries_w = $clog2(max_tries + 1);
   localparam int timer_w = $clog2(timeout_cycles + 1);

   localparam logic [card_width:0] users_lim  = (card_width + 1)'(users_num);
   localparam logic [tries_w-1:0]  tries_max  = tries_w'(max_tries);
   localparam logic [timer_w-1:0]  timer_last = timer_w'(timeout_cycles - 1);

   state_t                     state_q, state_d;
   logic [card_width-1:0]      card_sel_q, card_sel_d;
   logic [tries_w-1:0]         tries_q, tries_d;
   logic [timer_w-1:0]         timer_q, timer_d;
   logic [balance_width-1:0]   upd_bal_q, upd_bal_d;
   logic [balance_width-1:0]   bal_out_q, bal_out_d;
   logic                       card_in_q, card_in_d;
   logic                       card_out_q, card_out_d;
   logic                       op_done_q, op_done_d;
   logic                       wrong_id_q, wrong_id_d;
   logic                       wrong_psw_q, wrong_psw_d;
   logic                       locked_q, locked_d;
   logic                       op_err_q, op_err_d;

   // One extra bit on the sum catches deposit overflow.
   logic [balance_width:0]     dep_sum;
   logic [balance_width-1:0]   wdr_diff;
   logic [tries_w-1:0]         tries_inc;
   logic                       card_ok;

   assign dep_sum   = {1'b0, upd_bal_q} + {1'b0, amount};
   assign wdr_diff  = upd_bal_q - amount;
   assign tries_inc = tries_q + 1'b1;
   assign card_ok   = ({1'b0, card_number} < users_lim);

   // -------------------------------------------------------------------------
   // State register and all registered outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         card_sel_q  <= '0;
         tries_q     <= '0;
         timer_q     <= '0;
         upd_bal_q   <= '0;
         bal_out_q   <= '0;
         card_in_q   <= 1'b0;
         card_out_q  <= 1'b0;
         op_done_q   <= 1'b0;
         wrong_id_q  <= 1'b0;
         wrong_psw_q <= 1'b0;
         locked_q    <= 1'b0;
         op_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         card_sel_q  <= card_sel_d;
         tries_q     <= tries_d;
         timer_q     <= timer_d;
         upd_bal_q   <= upd_bal_d;
         bal_out_q   <= bal_out_d;
         card_in_q   <= card_in_d;
         card_out_q  <= card_out_d;
         op_done_q   <= op_done_d;
         wrong_id_q  <= wrong_id_d;
         wrong_psw_q <= wrong_psw_d;
         locked_q    <= locked_d;
         op_err_q    <= op_err_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and next-output logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      card_sel_d  = card_sel_q;
      tries_d     = tries_q;
      timer_d     = '0;
      upd_bal_d   = upd_bal_q;
      bal_out_d   = bal_out_q;
      op_done_d   = 1'b0;
      wrong_id_d  = 1'b0;
      wrong_psw_d = 1'b0;
      locked_d    = 1'b0;
      op_err_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (card_inserted) begin
               if (card_ok) begin
                  card_sel_d = card_number;
                  state_d    = LOAD;
               end else begin
                  wrong_id_d = 1'b1;
               end
            end
         end

         LOAD: begin
            state_d = WAIT_PIN;
         end

         WAIT_PIN: begin
            // Track the storage block so the working balance is current on
            // MENU entry and on a lockout eject.
            upd_bal_d = stored_balance;
            timer_d   = timer_q + 1'b1;
            if (pin_valid) begin
               timer_d = '0;
               if (pin == stored_psw) begin
                  tries_d = '0;
                  state_d = MENU;
               end else begin
                  wrong_psw_d = 1'b1;
                  if (tries_inc == tries_max) begin
                     locked_d = 1'b1;
                     tries_d  = '0;
                     state_d  = EJECT;
                  end else begin
                     tries_d = tries_inc;
                  end
               end
            end else if (timer_q == timer_last) begin
               state_d = EJECT;
            end
         end

         MENU: begin
            timer_d = timer_q + 1'b1;
            if (op_valid) begin
               // A request in the terminal timeout cycle is served instead.
               timer_d = '0;
               case (op_code)
                  2'b00: begin
                     bal_out_d = upd_bal_q;
                     op_done_d = 1'b1;
                  end
                  2'b01: begin
                     if (amount <= upd_bal_q) begin
                        upd_bal_d = wdr_diff;
                        op_done_d = 1'b1;
                     end else begin
                        op_err_d = 1'b1;
                     end
                  end
                  2'b10: begin
                     if (dep_sum[balance_width]) begin
                        op_err_d = 1'b1;
                     end else begin
                        upd_bal_d = dep_sum[balance_width-1:0];
                        op_done_d = 1'b1;
                     end
                  end
                  2'b11: begin
                     state_d = EJECT;
                  end
               endcase
            end else if (timer_q == timer_last) begin
               state_d = EJECT;
            end
         end

         EJECT: begin
            // Balance is held here for the write-back; the card ID goes away
            // as the session returns to IDLE.
            state_d    = IDLE;
            card_sel_d = '0;
            tries_d    = '0;
         end

         default: begin
            state_d    = IDLE;
            card_sel_d = '0;
            tries_d    = '0;
         end
      endcase

      // The idle timer only survives while the session stays in one state.
      if (state_d != state_q) begin
         timer_d = '0;
      end

      // Load/eject strobes are high for the single cycle spent in LOAD/EJECT.
      card_in_d  = (state_q == IDLE) && (state_d == LOAD);
      card_out_d = (state_q != EJECT) && (state_d == EJECT);
   end

   assign state           = state_q;
   assign card_sel        = card_sel_q;
   assign card_in         = card_in_q;
   assign card_out        = card_out_q;
   assign op_done         = op_done_q;
   assign updated_balance = upd_bal_q;
   assign balance_out     = bal_out_q;
   assign wrong_id        = wrong_id_q;
   assign wrong_psw       = wrong_psw_q;
   assign locked          = locked_q;
   assign op_err          = op_err_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// -----------------------------------------------------------------------------
// tb_atm_session_ctrl
//
// Directed scenarios plus randomized sessions. A transaction-level session
// model predicts every registered output each cycle; a small array stands in
// for the account storage block (write-back on op_done/card_out).
// -----------------------------------------------------------------------------
module tb_atm_session_ctrl;

   localparam int CW = 6;
   localparam int PW = 16;
   localparam int BW = 20;
   localparam int UN = 10;
   localparam int MT = 3;
   localparam int TO = 1000;

   localparam int S_IDLE  = 0;
   localparam int S_LOAD  = 1;
   localparam int S_WAIT  = 2;
   localparam int S_MENU  = 3;
   localparam int S_EJECT = 4;

   localparam longint BAL_MAX = (longint'(1) << BW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          card_inserted;
   logic [CW-1:0] card_number;
   logic [PW-1:0] pin;
   logic          pin_valid;
   logic [PW-1:0] stored_psw;
   logic [BW-1:0] stored_balance;
   logic          op_valid;
   logic [1:0]    op_code;
   logic [BW-1:0] amount;
   logic [CW-1:0] card_sel;
   logic          card_in;
   logic          card_out;
   logic          op_done;
   logic [BW-1:0] updated_balance;
   logic [BW-1:0] balance_out;
   logic          wrong_id;
   logic          wrong_psw;
   logic          locked;
   logic          op_err;
   logic [2:0]    state;

   atm_session_ctrl #(
      .card_width(CW), .password_width(PW), .balance_width(BW),
      .users_num(UN), .max_tries(MT), .timeout_cycles(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .card_inserted(card_inserted), .card_number(card_number),
      .pin(pin), .pin_valid(pin_valid),
      .stored_psw(stored_psw), .stored_balance(stored_balance),
      .op_valid(op_valid), .op_code(op_code), .amount(amount),
      .card_sel(card_sel), .card_in(card_in), .card_out(card_out),
      .op_done(op_done), .updated_balance(updated_balance),
      .balance_out(balance_out), .wrong_id(wrong_id),
      .wrong_psw(wrong_psw), .locked(locked), .op_err(op_err),
      .state(state)
   );

   always #5 clk = ~clk;

   // ---------------- storage block stand-in ----------------
   logic [PW-1:0] psw_mem [64];
   logic [BW-1:0] bal_mem [64];

   assign stored_psw     = psw_mem[card_sel];
   assign stored_balance = bal_mem[card_sel];

   always @(posedge clk) begin
      if (!rst && (card_out || op_done)) bal_mem[card_sel] = updated_balance;
   end

   // ---------------- counters ----------------
   int checks = 0;
   int passes = 0;
   int cyc    = 0;
   bit armed  = 1'b0;

   always @(posedge clk) cyc++;

   // ---------------- session model ----------------
   int            m_state, m_tries, m_quiet;
   logic [CW-1:0] m_card;
   longint        m_bal, m_bout;
   bit e_card_in, e_card_out, e_op_done, e_wrong_id, e_wrong_psw, e_locked, e_op_err;

   task automatic m_eject();
      m_state    = S_EJECT;
      e_card_out = 1'b1;
      m_tries    = 0;
      m_quiet    = 0;
   endtask

   always @(posedge clk or posedge rst) begin
      e_card_in = 0; e_card_out = 0; e_op_done = 0; e_wrong_id = 0;
      e_wrong_psw = 0; e_locked = 0; e_op_err = 0;
      if (rst) begin
         m_state = S_IDLE; m_tries = 0; m_quiet = 0;
         m_card = '0; m_bal = 0; m_bout = 0;
      end else begin
         case (m_state)
            S_IDLE: if (card_inserted) begin
               if (int'(card_number) < UN) begin
                  m_card = card_number; m_state = S_LOAD; e_card_in = 1;
               end else e_wrong_id = 1;
            end
            S_LOAD: begin m_state = S_WAIT; m_quiet = 0; end
            S_WAIT: begin
               m_bal = longint'(stored_balance);
               if (pin_valid) begin
                  m_quiet = 0;
                  if (pin == stored_psw) begin m_tries = 0; m_state = S_MENU; end
                  else begin
                     e_wrong_psw = 1;
                     m_tries++;
                     if (m_tries >= MT) begin e_locked = 1; m_eject(); end
                  end
               end else begin
                  m_quiet++;
                  if (m_quiet >= TO) m_eject();
               end
            end
            S_MENU: begin
               if (op_valid) begin
                  m_quiet = 0;
                  case (op_code)
                     2'd0: begin m_bout = m_bal; e_op_done = 1; end
                     2'd1: if (longint'(amount) <= m_bal) begin m_bal = m_bal - longint'(amount); e_op_done = 1; end
                           else e_op_err = 1;
                     2'd2: if (m_bal + longint'(amount) <= BAL_MAX) begin m_bal = m_bal + longint'(amount); e_op_done = 1; end
                           else e_op_err = 1;
                     default: m_eject();
                  endcase
               end else begin
                  m_quiet++;
                  if (m_quiet >= TO) m_eject();
               end
            end
            default: begin m_state = S_IDLE; m_card = '0; end
         endcase
      end
   end

   function automatic logic [56:0] dut_vec();
      return {state, card_sel, card_in, card_out, op_done, updated_balance,
              balance_out, wrong_id, wrong_psw, locked, op_err};
   endfunction

   function automatic logic [56:0] exp_vec();
      return {3'(m_state), m_card, e_card_in, e_card_out, e_op_done, BW'(m_bal),
              BW'(m_bout), e_wrong_id, e_wrong_psw, e_locked, e_op_err};
   endfunction

   // Every-cycle comparison against the model.
   always @(posedge clk) begin
      #1;
      if (armed && !rst) begin
         checks++;
         if (dut_vec() === exp_vec()) passes++;
         else $display("FAIL cycle %0d model_cmp: got %h want %h (state got %0d want %0d)",
                       cyc, dut_vec(), exp_vec(), state, m_state);
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL cycle %0d %s: got %0d want %0d", cyc, name, act, exp);
   endtask

   task automatic cycle();
      @(posedge clk);
      #2;
      card_inserted = 1'b0;
      pin_valid     = 1'b0;
      op_valid      = 1'b0;
   endtask

   task automatic login(input int c, input logic [PW-1:0] p);
      card_inserted = 1'b1; card_number = CW'(c);
      cycle();
      chk("load_state", state, S_LOAD);
      chk("card_in_hi", card_in, 1);
      cycle();
      chk("wait_state", state, S_WAIT);
      chk("card_in_lo", card_in, 0);
      pin_valid = 1'b1; pin = p;
      cycle();
      chk("menu_state", state, S_MENU);
   endtask

   task automatic do_op(input logic [1:0] code, input longint amt);
      op_valid = 1'b1; op_code = code; amount = BW'(amt);
      cycle();
   endtask

   initial begin
      rst = 1'b1; card_inserted = 0; card_number = '0; pin = '0; pin_valid = 0;
      op_valid = 0; op_code = '0; amount = '0;
      for (int i = 0; i < 64; i++) begin
         psw_mem[i] = PW'($urandom);
         bal_mem[i] = BW'($urandom);
      end
      psw_mem[3] = 16'h1234; bal_mem[3] = 20'd500;
      psw_mem[5] = 16'h0005; bal_mem[5] = 20'hFFFFF;
      psw_mem[7] = 16'h7777; bal_mem[7] = 20'd4242;

      repeat (3) cycle();
      chk("reset_state", state, 0);
      chk("reset_outputs", longint'(dut_vec()), 0);
      rst = 1'b0;
      armed = 1'b1;
      cycle();

      // Card 3, correct PIN, withdraw/deposit/underflow/exit
      login(3, 16'h1234);
      chk("menu_balance", updated_balance, 500);
      do_op(2'd1, 100);
      chk("wd_done", op_done, 1);
      chk("wd_bal", updated_balance, 400);
      do_op(2'd2, 100);
      chk("dep_bal", updated_balance, 500);
      do_op(2'd1, 600);
      chk("under_err", op_err, 1);
      chk("under_nodone", op_done, 0);
      chk("under_bal", updated_balance, 500);
      do_op(2'd3, 0);
      chk("exit_state", state, S_EJECT);
      chk("exit_card_out", card_out, 1);
      cycle();
      chk("idle_state", state, S_IDLE);
      chk("idle_card_sel", card_sel, 0);
      chk("idle_card_out", card_out, 0);

      // Invalid card ID
      card_inserted = 1'b1; card_number = 6'd12;
      cycle();
      chk("wrong_id_hi", wrong_id, 1);
      chk("wrong_id_state", state, S_IDLE);
      cycle();
      chk("wrong_id_lo", wrong_id, 0);
      chk("wrong_id_no_load", card_in, 0);

      // Lockout after three wrong PINs
      card_inserted = 1'b1; card_number = 6'd7;
      cycle(); cycle();
      for (int k = 1; k <= 3; k++) begin
         pin_valid = 1'b1; pin = 16'h0001;
         cycle();
         chk("wrong_psw", wrong_psw, 1);
         chk("locked", locked, (k == 3) ? 1 : 0);
         chk("lock_state", state, (k == 3) ? S_EJECT : S_WAIT);
      end
      chk("lock_card_out", card_out, 1);
      chk("lock_balance", updated_balance, 4242);
      cycle();

      // Deposit overflow at full-scale balance
      login(5, 16'h0005);
      do_op(2'd2, 1);
      chk("ovf_err", op_err, 1);
      chk("ovf_nodone", op_done, 0);
      chk("ovf_bal", updated_balance, BAL_MAX);
      do_op(2'd3, 0);
      cycle();

      // Idle timeout in MENU
      login(3, 16'h1234);
      repeat (TO - 1) cycle();
      chk("to_before", state, S_MENU);
      cycle();
      chk("to_eject", state, S_EJECT);
      chk("to_card_out", card_out, 1);
      cycle();

      // Request in the terminal cycle wins and restarts the timer
      login(3, 16'h1234);
      repeat (TO - 1) cycle();
      do_op(2'd0, 0);
      chk("late_done", op_done, 1);
      chk("late_state", state, S_MENU);
      chk("late_bout", balance_out, 500);
      repeat (TO - 1) cycle();
      chk("late_restart", state, S_MENU);
      cycle();
      chk("late_eject", state, S_EJECT);
      cycle();

      // Asynchronous reset mid-session
      login(3, 16'h1234);
      do_op(2'd2, 7);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_state", state, 0);
      chk("arst_card_out", card_out, 0);
      chk("arst_outputs", longint'(dut_vec()), 0);
      repeat (2) cycle();
      rst = 1'b0;
      cycle();

      // Randomized sessions
      for (int n = 0; n < 5000; n++) begin
         case (m_state)
            S_IDLE: if ($urandom_range(3) == 0) begin
               card_inserted = 1'b1; card_number = CW'($urandom_range(15));
            end
            S_WAIT: if ($urandom_range(2) == 0) begin
               pin_valid = 1'b1;
               pin = ($urandom_range(2) != 0) ? stored_psw : PW'($urandom);
            end
            S_MENU: if ($urandom_range(2) == 0) begin
               op_valid = 1'b1;
               op_code  = ($urandom_range(11) == 0) ? 2'd3 : 2'($urandom_range(2));
               case ($urandom_range(4))
                  0: amount = BW'($urandom_range(1000));
                  1: amount = BW'($urandom);
                  2: amount = BW'(m_bal);
                  3: amount = BW'(BAL_MAX - m_bal);
                  default: amount = BW'(BAL_MAX - m_bal + 1);
               endcase
            end
            default: ;
         endcase
         if (m_state != S_IDLE && $urandom_range(7) == 0) begin
            card_inserted = 1'b1; card_number = CW'($urandom_range(15));
         end
         if ((m_state == S_IDLE || m_state == S_LOAD || m_state == S_EJECT) &&
             $urandom_range(7) == 0) begin
            op_valid = 1'b1; op_code = 2'($urandom_range(3)); amount = BW'($urandom);
         end
         cycle();
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
- Session FSM that sequences the card/account storage block for one ATM transaction.
- Accepts a card, requests a password/balance load, and checks the PIN with a retry limit.
- Serves balance, withdraw and deposit requests against a working balance, then ejects the card.
- Drives the storage block's card select, load, op_done and card-out strobes.
- Sits between the front-panel input logic and the account storage block.

Parameters:
- card_width, 6, card number width.
- password_width, 16, PIN width.
- balance_width, 20, balance and amount width.
- users_num, 10, number of valid accounts (IDs 0..users_num-1).
- max_tries, 3, wrong PINs allowed before lockout.
- timeout_cycles, 1000, idle cycles in WAIT_PIN/MENU before forced eject.

Ports:
- clk  in  1  system clock; one clock, all logic on rising edge.
- rst  in  1  reset; asynchronous and active-high.
- card_inserted  in  1  one-cycle pulse, card presented.
- card_number  in  card_width  card ID; sampled only with card_inserted.
- pin  in  password_width  entered PIN.
- pin_valid  in  1  one-cycle pulse, pin is valid.
- stored_psw  in  password_width  password from storage block.
- stored_balance  in  balance_width  balance from storage block.
- op_valid  in  1  one-cycle pulse, operation request.
- op_code  in  2  00 balance, 01 withdraw, 10 deposit, 11 exit.
- amount  in  balance_width  operand for withdraw/deposit.
- card_sel  out  card_width  latched card ID to storage block.
- card_in  out  1  load strobe to storage block.
- card_out  out  1  eject strobe; storage block writes back on it.
- op_done  out  1  operation-complete strobe; storage block writes back on it.
- updated_balance  out  balance_width  working balance.
- balance_out  out  balance_width  balance shown to user.
- wrong_id  out  1  pulse, invalid card ID.
- wrong_psw  out  1  pulse, PIN mismatch.
- locked  out  1  pulse, retry limit reached.
- op_err  out  1  pulse, withdraw underflow or deposit overflow.
- state  out  3  IDLE=0, LOAD=1, WAIT_PIN=2, MENU=3, EJECT=4.

Behaviour:
- Reset: state=IDLE. All outputs 0, including card_sel, updated_balance and balance_out. Tries and timeout counters are 0.
- Reset mid-session: returns to IDLE immediately. No card_out and no write-back are issued.
- All outputs are registered. Every strobe and error output is high for exactly one cycle.
- IDLE:
  - card_inserted with card_number<users_num: latch card_sel, go to LOAD.
  - card_inserted with card_number>=users_num: wrong_id pulse, stay in IDLE.
  - card_inserted is ignored in all other states.
- LOAD: card_in=1 for this single cycle, then go to WAIT_PIN. stored_psw and stored_balance are valid from the first WAIT_PIN cycle onward.
- WAIT_PIN:
  - updated_balance <= stored_balance every cycle.
  - pin_valid with pin==stored_psw: go to MENU; tries=0, timeout=0.
  - pin_valid with a mismatch: wrong_psw pulse, tries+1. If the new tries==max_tries, also pulse locked and go to EJECT; otherwise stay.
- MENU (updated_balance holds the working balance; op_valid is sampled only here):
  - 00 balance: balance_out <= updated_balance; op_done pulse.
  - 01 withdraw, amount<=balance: balance-=amount; op_done pulse in the same cycle as the new updated_balance.
  - 01 withdraw, amount>balance: op_err pulse; no op_done; balance unchanged.
  - 10 deposit, sum fits balance_width: balance+=amount; op_done pulse.
  - 10 deposit, sum exceeds 2^balance_width-1: op_err pulse; no op_done; balance unchanged.
  - 11 exit: go to EJECT.
- Timeout:
  - The counter runs in WAIT_PIN and MENU and clears on pin_valid, op_valid and any state change.
  - Reaching timeout_cycles-1 forces EJECT.
  - pin_valid or op_valid in the terminal cycle wins: the request is served and the counter clears.
- EJECT: card_out=1 for one cycle. updated_balance stays stable for the write-back. Next state is IDLE; card_sel is cleared on IDLE entry.
- Arithmetic: unsigned. Overflow is detected using a balance_width+1 bit sum.

Test Plan:
- Reset, then card 3 with correct PIN, withdraw 100 from balance 500: card_in high 1 cycle; MENU reached; op_done coincides with updated_balance=400.
- card_number=12 with users_num=10: wrong_id single pulse; state stays 0; card_in never asserted.
- Three wrong PINs: three wrong_psw pulses; locked and the transition to EJECT on the 3rd; card_out with updated_balance=stored value.
- Withdraw 600 from balance 500: op_err pulse, no op_done, balance 500. Deposit 1 at balance 2^20-1: op_err, no change.
- No input in MENU for 1000 cycles: EJECT, card_out pulse. An op_valid at cycle 999 is served and the counter is cleared instead.
- Assert rst while in MENU: state=0 asynchronously; no card_out; all outputs 0.
